rvj1_ifu: RTL
=============

# rvj1_ifu

Instruction fetch unit for the rvj1 core. It sits directly upstream of the controller and the decode stage. It fetches 32-bit words from the instruction memory port and buffers them in a small prefetch FIFO. It presents the oldest word to decode and pulses `instr_issued_o`, which the controller uses to advance its program counter. Fetching begins only when the controller supplies a jump address, either at boot or on redirect. A jump flushes everything in flight.

## Interface
- `DEPTH`, default 2: prefetch FIFO entries, and also the cap on outstanding memory requests. Legal values are 2 or 4.
- `clk_i`  in  1  core clock; all logic is on the rising edge.
- `rst_i`  in  1  reset: one clock, synchronous, active-high.
- `jmp_addr_valid_i`  in  1  redirect strobe from the controller.
- `jmp_addr_i`  in  32  redirect target. Bits [1:0] are ignored and treated as 00.
- `stall_i`  in  1  hazard stall from the controller; blocks issue.
- `imem_req_o`  out  1  fetch request.
- `imem_addr_o`  out  32  word-aligned fetch address.
- `imem_gnt_i`  in  1  request accepted in this cycle.
- `imem_rvalid_i`  in  1  read data valid. Responses arrive in order, at least 1 cycle after grant.
- `imem_rdata_i`  in  32  read data.
- `instr_o`  out  32  head-of-FIFO instruction.
- `instr_valid_o`  out  1  `instr_o` is valid.
- `instr_issued_o`  out  1  the head instruction is consumed in this cycle.

## Operation
- **FSM states:** IDLE and RUN.
  - Reset puts the FSM in IDLE.
  - IDLE moves to RUN on `jmp_addr_valid_i`.
  - RUN stays in RUN.
  - In IDLE, `imem_req_o` is 0 and responses are ignored.
- **Fetch PC:** `fetch_pc` holds the address of the next request. It resets to 0.
  - On `jmp_addr_valid_i`, `fetch_pc` loads `{jmp_addr_i[31:2],2'b00}`.
  - Otherwise, on `imem_req_o & imem_gnt_i`, it increments by 4, wrapping modulo 2^32.
- **Counters:**
  - `pend` counts granted requests whose data is still wanted.
  - `disc` counts granted requests whose data must be dropped.
  - `cnt` is the FIFO occupancy.
- **Request rule:** `imem_req_o = RUN & ~jmp_addr_valid_i & (cnt + pend + disc < DEPTH)`.
  - `imem_addr_o = fetch_pc`.
  - While a request is waiting for grant, address and request are held stable.
- **Response handling:** on `imem_rvalid_i`:
  - If `disc > 0`: decrement `disc` and drop the data.
  - Else: decrement `pend` and push `imem_rdata_i` into the FIFO.
  - The occupancy cap guarantees the FIFO never overflows.
- **Issue:** `instr_issued_o = instr_valid_o & ~stall_i & ~jmp_addr_valid_i`. Issue pops the FIFO head.
- **Jump/flush:** on `jmp_addr_valid_i`:
  - FIFO is emptied (`cnt` becomes 0).
  - `disc <= disc + pend - (imem_rvalid_i ? 1 : 0)`, with the response counted against `disc` first.
  - `pend` becomes 0.
  - A grant in the jump cycle cannot occur, because no request is driven in that cycle.
  - Jump has priority over issue and over push.
- **Simultaneous push and pop:** allowed at any occupancy, including full; `cnt` is unchanged.
- **Reset mid-operation:**
  - All counters, FIFO and FSM are cleared.
  - Late responses after reset are ignored until a jump occurs.
  - After that jump they are treated as data, so the bench must quiesce memory around reset.

## Timing
- **Reset values:**
  - `imem_req_o` = 0, `imem_addr_o` = 0.
  - `instr_o` = 0, `instr_valid_o` = 0, `instr_issued_o` = 0.
- **Jump to first request:** a jump in cycle N gives `imem_req_o`=1 with `imem_addr_o` = target in cycle N+1.
- **Response to decode:** a response in cycle M gives `instr_valid_o`=1 in cycle M+1. The FIFO output is registered and there is no bypass.
- **Issue:** `instr_issued_o` is combinational from `instr_valid_o`, `stall_i` and `jmp_addr_valid_i` in the same cycle.
- **Throughput:** with `gnt` always 1, 1-cycle response latency and no stall, the unit sustains 1 instruction per cycle after a 2-cycle fill.
- **Flush visibility:** `instr_valid_o` drops in the cycle after a jump and stays low until the first response for the new target returns.

## Test plan
- **Boot:** reset, then jump to 0x8000_0000 with memory returning `addr^0xA5A5A5A5` after 1 cycle and no stall.
  - Requests go to 0x8000_0000, 0x8000_0004, …
  - `instr_o` sequence matches, with 1 issue per cycle from cycle 3 after the jump.
- **Stall:** hold `stall_i`=1 for 5 cycles in steady state.
  - `instr_issued_o`=0 and `instr_o` is held.
  - FIFO fills to `DEPTH`, then `imem_req_o` drops.
  - On release, issue resumes with no lost or duplicated words.
- **Grant backpressure:** `imem_gnt_i`=0 for 3 cycles.
  - `imem_req_o` stays high and `imem_addr_o` stays stable.
  - `fetch_pc` advances only on grant.
- **Redirect with 2 outstanding:** jump to 0x0000_0100 while `pend`=2 and responses have 3-cycle latency.
  - Both old responses are dropped.
  - The first issued instruction is the word from 0x100.
- **Jump with simultaneous response and issue:**
  - No issue occurs in the jump cycle.
  - The response is discarded and `disc` is computed correctly.
  - `instr_valid_o`=0 in the next cycle.
- **Wrap and reset:**
  - Jump to 0xFFFF_FFFC; the next request address is 0x0000_0000.
  - Assert `rst_i` mid-stream; all outputs read 0 the next cycle and the FSM returns to IDLE.

Source files
------------

// File: rtl/rvj1_ifu_if.sv
// Instruction-memory port of the rvj1 fetch unit, grouped so the IFU and a
// memory model or arbiter can be wired with a single connection.
//
// Handshake: a request transfers in any cycle where imem_req_o and imem_gnt_i
// are both high. While imem_req_o is high and imem_gnt_i is low, imem_req_o
// and imem_addr_o hold their values. imem_rvalid_i is a one-cycle strobe with
// no backpressure; responses return in request order, at least one cycle
// after their grant.
interface rvj1_ifu_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/rvj1_ifu.sv
// rvj1 instruction fetch unit: jump-started sequential fetch into a small
// prefetch FIFO, with jump flush that discards responses still in flight.
module rvj1_ifu #(
  parameter int DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        jmp_addr_valid_i,
  input  logic [31:0] jmp_addr_i,
  input  logic        stall_i,
  rvj1_ifu_if.master  imem,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic        instr_issued_o,
  output logic        dbg_state_o
);

  localparam int CW = $clog2(DEPTH) + 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] cnt;
  logic [CW-1:0] pend;
  logic [CW-1:0] disc;
  logic [31:0]   fifo_q [DEPTH];

  logic          run;
  logic          req;
  logic          gnt;
  logic          rsp;
  logic          rsp_drop;
  logic          push;
  logic          pop;
  logic [CW-1:0] wr_idx;

  assign run      = (state == RUN);
  // Everything granted but not yet retired (kept, dropped or buffered) counts
  // against the FIFO, so a response always has a free slot when it lands.
  assign req      = run & ~jmp_addr_valid_i & ((cnt + pend + disc) < CW'(DEPTH));
  assign gnt      = req & imem.imem_gnt_i;
  assign rsp      = run & imem.imem_rvalid_i;
  assign rsp_drop = rsp & (disc != '0);
  assign push     = rsp & (disc == '0);

  assign instr_valid_o  = (cnt != '0);
  assign instr_issued_o = instr_valid_o & ~stall_i & ~jmp_addr_valid_i;
  assign pop            = instr_issued_o;
  assign instr_o        = fifo_q[0];
  assign dbg_state_o    = state;

  assign imem.imem_req_o  = req;
  assign imem.imem_addr_o = fetch_pc;

  // Head lives in entry 0; a simultaneous pop moves the write slot down by one.
  assign wr_idx = pop ? (cnt - CW'(1)) : cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      fetch_pc <= '0;
      cnt      <= '0;
      pend     <= '0;
      disc     <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      if (jmp_addr_valid_i) state <= RUN;

      if (jmp_addr_valid_i)  fetch_pc <= {jmp_addr_i[31:2], 2'b00};
      else if (gnt)          fetch_pc <= fetch_pc + 32'd4;

      if (jmp_addr_valid_i) begin
        // Wanted requests become unwanted; a response this cycle retires one.
        cnt  <= '0;
        pend <= '0;
        disc <= disc + pend - CW'(rsp);
      end else begin
        cnt  <= cnt + CW'(push) - CW'(pop);
        pend <= pend + CW'(gnt) - CW'(push);
        disc <= disc - CW'(rsp_drop);
        for (int i = 0; i < DEPTH - 1; i++) begin
          if (push && (CW'(i) == wr_idx)) fifo_q[i] <= imem.imem_rdata_i;
          else if (pop)                   fifo_q[i] <= fifo_q[i+1];
        end
        if (push && (CW'(DEPTH - 1) == wr_idx)) fifo_q[DEPTH-1] <= imem.imem_rdata_i;
      end
    end
  end

endmodule
